cpu_run_ctl: RTL and testbench

Run/halt/interrupt controller for the CPU, driving the halt and interrupt inputs that the reset/boot sequencer currently ties low. It debounces the halt (button_h) and continue (button_c) push buttons in the cpuclk domain and sequences halt, single-step and resume with the CPU through a halt/halted handshake. It also raises a console interrupt with ack and timeout. It sits beside the reset/boot sequencer and consumes that sequencer's cpu reset and boot outputs.

---
 rtl/cpu_run_ctl_pkg.sv | 14 +
 rtl/cpu_run_ctl_debounce.sv | 52 +++++
 rtl/cpu_run_ctl.sv | 125 ++++++++++++
 tb/tb_cpu_run_ctl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctl_pkg.sv
// Shared definitions for the CPU run/halt/interrupt controller.
package cpu_run_ctl_pkg;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_HALTING = 3'd1,
    S_HALTED  = 3'd2,
    S_STEP    = 3'd3,
    S_RESUME  = 3'd4
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cpu_run_ctl_debounce.sv
// Push-button debouncer: synchronizer, sampled hold history and a single
// press pulse per continuous hold.
module button_debounce
  import cpu_run_ctl_pkg::*;
#(
  parameter int DEB_LEN = 10
) (
  input  logic cpuclk,
  input  logic dcm_reset,
  input  logic btn,
  input  logic tick,
  input  logic discard,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_LEN-1:0]     hold_q, hold_d, hold_new;
  logic                   hist_q, hist_d;
  logic                   press_q, press_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn};
    hold_new = {hold_q[DEB_LEN-2:0], sync_q[SYNC_STAGES-1]};
    hold_d   = hold_q;
    hist_d   = hist_q;
    press_d  = 1'b0;
    if (tick) begin
      hold_d  = hold_new;
      hist_d  = &hold_new;
      // hist keeps tracking while discarded, so a button held across a
      // CPU reset cannot fire once the reset drops
      press_d = (&hold_new) && !hist_q && !discard;
    end
  end

  always_ff @(posedge cpuclk or posedge dcm_reset) begin
    if (dcm_reset) begin
      sync_q  <= '0;
      hold_q  <= '0;
      hist_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hold_q  <= hold_d;
      hist_q  <= hist_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/cpu_run_ctl.sv
// CPU run/halt/single-step sequencer with debounced buttons and a console
// interrupt that times out into a sticky lost flag.
module cpu_run_ctl
  import cpu_run_ctl_pkg::*;
#(
  parameter int TICK_BITS   = 10,
  parameter int DEB_LEN     = 10,
  parameter int IRQ_TO_BITS = 16
) (
  input  logic cpuclk,
  input  logic dcm_reset,
  input  logic cpu_reset,
  input  logic boot,
  input  logic button_h,
  input  logic button_c,
  input  logic cpu_halted,
  input  logic irq_ack,
  output logic halt,
  output logic interrupt,
  output logic halted_led,
  output logic irq_lost
);

  logic [TICK_BITS-1:0]   tick_cnt_q, tick_cnt_d;
  logic                   tick;
  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic                   rst_s;
  logic                   press_h, press_c;
  state_t                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic [IRQ_TO_BITS-1:0] irq_cnt_q, irq_cnt_d;
  logic                   irq_lost_q, irq_lost_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_BITS'(1);
    tick       = &tick_cnt_q;
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], cpu_reset};
    rst_s      = rst_sync_q[SYNC_STAGES-1];
  end

  button_debounce #(.DEB_LEN(DEB_LEN)) u_deb_h (
    .cpuclk    (cpuclk),
    .dcm_reset (dcm_reset),
    .btn       (button_h),
    .tick      (tick),
    .discard   (rst_s),
    .press     (press_h)
  );

  button_debounce #(.DEB_LEN(DEB_LEN)) u_deb_c (
    .cpuclk    (cpuclk),
    .dcm_reset (dcm_reset),
    .btn       (button_c),
    .tick      (tick),
    .discard   (rst_s),
    .press     (press_c)
  );

  always_comb begin
    state_d    = state_q;
    halt       = 1'b0;
    halted_led = 1'b0;
    if (rst_s) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:     if (press_h) state_d = S_HALTING;
        S_HALTING: if (cpu_halted) state_d = S_HALTED;
        S_HALTED: begin
          if (press_c)      state_d = S_RESUME;
          else if (press_h) state_d = S_STEP;
        end
        S_STEP:    state_d = S_HALTING;
        S_RESUME:  if (!cpu_halted) state_d = S_RUN;
        default:   state_d = S_RUN;
      endcase
    end
    // boot masks the request without disturbing the sequence
    halt       = ((state_q == S_HALTING) || (state_q == S_HALTED)) && !boot;
    halted_led = (state_q == S_HALTED);
  end

  always_comb begin
    pend_d     = pend_q;
    irq_cnt_d  = '0;
    irq_lost_d = irq_lost_q;
    if (rst_s) begin
      pend_d     = 1'b0;
      irq_lost_d = 1'b0;
    end else if (pend_q) begin
      if (irq_ack) begin
        pend_d = 1'b0;
      end else if (&irq_cnt_q) begin
        pend_d     = 1'b0;
        irq_lost_d = 1'b1;
      end else begin
        irq_cnt_d = irq_cnt_q + IRQ_TO_BITS'(1);
      end
    end else if (press_c && (state_q == S_RUN)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge cpuclk or posedge dcm_reset) begin
    if (dcm_reset) begin
      tick_cnt_q <= '0;
      rst_sync_q <= '0;
      state_q    <= S_RUN;
      pend_q     <= 1'b0;
      irq_cnt_q  <= '0;
      irq_lost_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rst_sync_q <= rst_sync_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      irq_cnt_q  <= irq_cnt_d;
      irq_lost_q <= irq_lost_d;
    end
  end

  assign interrupt = pend_q;
  assign irq_lost  = irq_lost_q;

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Directed bench for cpu_run_ctl: a table of stimulus/expectation rows plus
// hand sequences for the timing-sensitive corners.
module tb_cpu_run_ctl;
  import cpu_run_ctl_pkg::*;

  logic cpuclk = 1'b0;
  logic dcm_reset, cpu_reset, boot, button_h, button_c, cpu_halted, irq_ack;
  logic halt, interrupt, halted_led, irq_lost;

  int n_tests = 0;
  int n_fail  = 0;
  int n_press_h = 0;

  cpu_run_ctl #(.TICK_BITS(2), .DEB_LEN(3), .IRQ_TO_BITS(4)) dut (
    .cpuclk     (cpuclk),
    .dcm_reset  (dcm_reset),
    .cpu_reset  (cpu_reset),
    .boot       (boot),
    .button_h   (button_h),
    .button_c   (button_c),
    .cpu_halted (cpu_halted),
    .irq_ack    (irq_ack),
    .halt       (halt),
    .interrupt  (interrupt),
    .halted_led (halted_led),
    .irq_lost   (irq_lost)
  );

  always #5 cpuclk = ~cpuclk;

  always @(negedge cpuclk) if (dut.press_h === 1'b1) n_press_h++;

  typedef enum int {OP_IDLE, OP_PRESS_H, OP_PRESS_C, OP_HALTED, OP_BOOT, OP_ACK} op_e;
  typedef struct {
    op_e  op;
    int   arg;
    logic e_halt;
    logic e_int;
    logic e_led;
    logic e_lost;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic h, input logic i, input logic l, input logic s);
    chk({nm, " halt"},       32'(halt),       32'(h));
    chk({nm, " interrupt"},  32'(interrupt),  32'(i));
    chk({nm, " halted_led"}, 32'(halted_led), 32'(l));
    chk({nm, " irq_lost"},   32'(irq_lost),   32'(s));
  endtask

  // returns at the negedge inside the cycle in which the press pulse is high
  task automatic press(input logic h, input logic c);
    logic ok;
    ok = 1'b0;
    repeat (10) @(negedge cpuclk);
    button_h = h;
    button_c = c;
    for (int i = 0; i < 40; i++) begin
      @(negedge cpuclk);
      if ((h && dut.press_h === 1'b1) || (c && dut.press_c === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    button_h = 1'b0;
    button_c = 1'b0;
    chk("press_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int   hi;
    int   n0;
    logic seen;

    vecs[0]  = '{OP_HALTED,  1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_BOOT,    1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{OP_BOOT,    0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{OP_PRESS_C, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_IDLE,    5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_HALTED,  0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_PRESS_C, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{OP_ACK,     0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_ACK,     0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_PRESS_H, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_PRESS_C, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_HALTED,  1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_PRESS_H, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_IDLE,    2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{OP_PRESS_C, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{OP_HALTED,  0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{OP_PRESS_H, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{OP_BOOT,    1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{OP_BOOT,    0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{OP_HALTED,  1, 1'b1, 1'b0, 1'b1, 1'b0};

    dcm_reset = 1'b1; cpu_reset = 1'b0; boot = 1'b0;
    button_h = 1'b0; button_c = 1'b0; cpu_halted = 1'b0; irq_ack = 1'b0;
    repeat (3) @(negedge cpuclk);
    chk_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    dcm_reset = 1'b0;
    @(negedge cpuclk);
    chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset state", 32'(dut.state_q), 32'(S_RUN));

    // bounce: period-6 toggling never yields three consecutive high samples
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge cpuclk);
      if (i % 3 == 0) button_h = ~button_h;
      seen = seen | halt;
    end
    chk("bounce halt", 32'(seen), 32'd0);
    chk("bounce press count", 32'(n_press_h), 32'd0);
    button_h = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge cpuclk);
      if (halt === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold halt within 16", 32'(seen), 32'd1);
    repeat (190) @(negedge cpuclk);
    chk("hold single press", 32'(n_press_h), 32'd1);
    button_h = 1'b0;

    for (int v = 0; v < NV; v++) begin
      case (vecs[v].op)
        OP_IDLE:    repeat (vecs[v].arg) @(negedge cpuclk);
        OP_PRESS_H: begin press(1'b1, 1'b0); @(negedge cpuclk); end
        OP_PRESS_C: begin press(1'b0, 1'b1); @(negedge cpuclk); end
        OP_HALTED:  begin cpu_halted = vecs[v].arg[0]; @(negedge cpuclk); end
        OP_BOOT:    begin boot = vecs[v].arg[0]; @(negedge cpuclk); end
        OP_ACK:     begin irq_ack = 1'b1; @(negedge cpuclk); irq_ack = 1'b0; end
        default:    @(negedge cpuclk);
      endcase
      chk_out($sformatf("vec%0d", v), vecs[v].e_halt, vecs[v].e_int, vecs[v].e_led, vecs[v].e_lost);
    end

    // exact single step from S_HALTED with cpu_halted held high
    press(1'b1, 1'b0);
    @(negedge cpuclk); chk_out("step c1", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge cpuclk); chk_out("step c2", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge cpuclk); chk_out("step c3", 1'b1, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1);
    @(negedge cpuclk); chk_out("resume", 1'b0, 1'b0, 1'b0, 1'b0);
    cpu_halted = 1'b0;
    @(negedge cpuclk);
    chk("resume to run", 32'(dut.state_q), 32'(S_RUN));

    // ack five cycles after the interrupt rises
    press(1'b0, 1'b1);
    @(negedge cpuclk);
    chk("irq raised", 32'(interrupt), 32'd1);
    repeat (4) @(negedge cpuclk);
    irq_ack = 1'b1;
    @(negedge cpuclk);
    irq_ack = 1'b0;
    chk("irq acked", 32'(interrupt), 32'd0);

    // ack in the final cycle beats the timeout
    press(1'b0, 1'b1);
    repeat (16) @(negedge cpuclk);
    chk("irq before last ack", 32'(interrupt), 32'd1);
    irq_ack = 1'b1;
    @(negedge cpuclk);
    irq_ack = 1'b0;
    chk_out("last-cycle ack", 1'b0, 1'b0, 1'b0, 1'b0);

    // unacknowledged interrupt times out
    press(1'b0, 1'b1);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cpuclk);
      if (interrupt === 1'b1) hi++;
      else break;
    end
    chk("irq high cycles", 32'(hi), 32'd16);
    chk("irq_lost set", 32'(irq_lost), 32'd1);
    repeat (5) @(negedge cpuclk);
    chk("irq_lost sticky", 32'(irq_lost), 32'd1);

    // CPU reset while halting with an interrupt pending
    press(1'b1, 1'b1);
    @(negedge cpuclk);
    chk_out("pre cpu_reset", 1'b1, 1'b1, 1'b0, 1'b1);
    cpu_reset = 1'b1;
    repeat (3) @(negedge cpuclk);
    chk_out("cpu_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    n0 = n_press_h;
    button_h = 1'b1;
    repeat (40) @(negedge cpuclk);
    cpu_reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge cpuclk);
      seen = seen | halt;
    end
    chk("held across reset halt", 32'(seen), 32'd0);
    chk("held across reset press", 32'(n_press_h - n0), 32'd0);
    button_h = 1'b0;
    press(1'b1, 1'b0);
    @(negedge cpuclk);
    chk("re-press halt", 32'(halt), 32'd1);

    // asynchronous reset in the middle of a cycle
    #1 dcm_reset = 1'b1;
    #1 chk_out("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge cpuclk);
    dcm_reset = 1'b0;
    repeat (2) @(negedge cpuclk);
    chk("after async reset state", 32'(dut.state_q), 32'(S_RUN));
    chk_out("after async reset", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
